// File: rtl/level_meter_pkg.sv
// Shared types and constants for the level meter calibration/percent path.
package level_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } ctrl_state_e;

  localparam int PCT_MAX = 100;
  localparam int PCT_W   = 7;

  // (operand - L) * 100 needs DATA_W + 7 bits; one quotient bit per cycle.
  function automatic int DIV_STEPS(input int data_w);
    return data_w + 7;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, NUM_W cycles from start.
module seq_divider #(
  parameter int NUM_W = 19,
  parameter int DEN_W = 12
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             start_i,
  input  logic [NUM_W-1:0] num_i,
  input  logic [DEN_W-1:0] den_i,
  output logic             done_o,
  output logic [NUM_W-1:0] quot_o
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic [DEN_W-1:0] rem_q;
  logic [DEN_W-1:0] den_q;
  logic [NUM_W-1:0] quot_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;

  logic [DEN_W-1:0] src_rem;
  logic [NUM_W-1:0] src_quot;
  logic [DEN_W-1:0] src_den;
  logic [DEN_W:0]   trial;
  logic [DEN_W:0]   trial_sub;
  logic             fits;
  logic [DEN_W-1:0] rem_d;
  logic [NUM_W-1:0] quot_d;

  // The start cycle performs the first step on the fresh operands, so the
  // final quotient bit lands NUM_W-1 edges after start.
  always_comb begin
    src_rem   = start_i ? '0 : rem_q;
    src_quot  = start_i ? num_i : quot_q;
    src_den   = start_i ? den_i : den_q;
    trial     = {src_rem, src_quot[NUM_W-1]};
    trial_sub = trial - {1'b0, src_den};
    fits      = (trial >= {1'b0, src_den});
    rem_d     = fits ? trial_sub[DEN_W-1:0] : trial[DEN_W-1:0];
    quot_d    = {src_quot[NUM_W-2:0], fits};
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      rem_q  <= '0;
      den_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q  <= rem_d;
        quot_q <= quot_d;
        den_q  <= den_i;
        cnt_q  <= CNT_W'(NUM_W - 1);
        done_q <= (NUM_W == 1);
      end else if (cnt_q != '0) begin
        rem_q  <= rem_d;
        quot_q <= quot_d;
        cnt_q  <= cnt_q - CNT_W'(1);
        done_q <= (cnt_q == CNT_W'(1));
      end
    end
  end

  assign done_o = done_q;
  assign quot_o = quot_q;

endmodule

// File: rtl/level_calib_ctrl.sv
// Stores high/low calibration points from button events and converts each
// level sample into a 0..100 percent fill level.
module level_calib_ctrl
  import level_meter_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter int DEFAULT_H = 4095,
  parameter int DEFAULT_L = 0
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  input  logic              reset_button_in,
  input  logic              saveH_in,
  input  logic              saveL_in,
  output logic [DATA_W-1:0] level_high,
  output logic [DATA_W-1:0] level_low,
  output logic [PCT_W-1:0]  percent,
  output logic              percent_valid,
  output logic              calib_error,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int NUM_W = DIV_STEPS(DATA_W);
  localparam logic [DATA_W-1:0] DEF_H = DATA_W'(DEFAULT_H);
  localparam logic [DATA_W-1:0] DEF_L = DATA_W'(DEFAULT_L);

  // Handshake: sample_valid is a one-cycle strobe with no back-pressure; a
  // strobe that arrives while busy is dropped (only last_sample sees it), and
  // percent_valid is a one-cycle strobe with percent stable until the next one.

  logic [DATA_W-1:0] last_sample_q;
  logic              prev_rst_q, prev_h_q, prev_l_q;
  logic [DATA_W-1:0] level_high_q, level_low_q;
  logic              calib_error_q;
  logic              evt_rst, evt_h, evt_l;

  assign evt_rst = reset_button_in & ~prev_rst_q;
  assign evt_h   = saveH_in & ~prev_h_q;
  assign evt_l   = saveL_in & ~prev_l_q;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      last_sample_q <= '0;
      prev_rst_q    <= 1'b0;
      prev_h_q      <= 1'b0;
      prev_l_q      <= 1'b0;
      level_high_q  <= DEF_H;
      level_low_q   <= DEF_L;
      calib_error_q <= 1'b0;
    end else begin
      prev_rst_q <= reset_button_in;
      prev_h_q   <= saveH_in;
      prev_l_q   <= saveL_in;
      if (sample_valid) last_sample_q <= sample;
      if (evt_rst) begin
        level_high_q <= DEF_H;
        level_low_q  <= DEF_L;
      end else begin
        if (evt_h) level_high_q <= last_sample_q;
        if (evt_l) level_low_q  <= last_sample_q;
      end
      calib_error_q <= (level_high_q <= level_low_q);
    end
  end

  ctrl_state_e       state_q;
  logic [DATA_W-1:0] operand_q, snap_h_q, snap_l_q;
  logic [PCT_W-1:0]  result_q, percent_q;
  logic              percent_valid_q, busy_q;

  logic              snap_err, below, above, clamp;
  logic [PCT_W-1:0]  clamp_val;
  logic [DATA_W-1:0] span_diff, div_den;
  logic [NUM_W-1:0]  div_num, div_quot;
  logic              div_start, div_done;
  logic              unused_quot_hi;

  always_comb begin
    snap_err  = (snap_h_q <= snap_l_q);
    below     = (operand_q <= snap_l_q);
    above     = (operand_q >= snap_h_q);
    clamp     = snap_err | below | above;
    clamp_val = (snap_err | below) ? '0 : PCT_W'(PCT_MAX);
    span_diff = operand_q - snap_l_q;
    div_num   = NUM_W'(span_diff) * NUM_W'(PCT_MAX);
    div_den   = snap_h_q - snap_l_q;
    div_start = (state_q == ST_PREP) && !clamp;
  end

  seq_divider #(
    .NUM_W (NUM_W),
    .DEN_W (DATA_W)
  ) u_div (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .start_i    (div_start),
    .num_i      (div_num),
    .den_i      (div_den),
    .done_o     (div_done),
    .quot_o     (div_quot)
  );

  // Quotient is always < PCT_MAX, so the upper bits are zero by construction.
  assign unused_quot_hi = ^div_quot[NUM_W-1:PCT_W];

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      operand_q       <= '0;
      snap_h_q        <= '0;
      snap_l_q        <= '0;
      result_q        <= '0;
      percent_q       <= '0;
      percent_valid_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      percent_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sample_valid) begin
            operand_q <= sample;
            snap_h_q  <= level_high_q;
            snap_l_q  <= level_low_q;
            busy_q    <= 1'b1;
            state_q   <= ST_PREP;
          end
        end
        ST_PREP: begin
          if (clamp) begin
            result_q <= clamp_val;
            state_q  <= ST_DONE;
          end else begin
            state_q <= ST_DIV;
          end
        end
        ST_DIV: begin
          if (div_done) begin
            result_q <= div_quot[PCT_W-1:0];
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          percent_q       <= result_q;
          percent_valid_q <= 1'b1;
          busy_q          <= 1'b0;
          state_q         <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign level_high    = level_high_q;
  assign level_low     = level_low_q;
  assign calib_error   = calib_error_q;
  assign percent       = percent_q;
  assign percent_valid = percent_valid_q;
  assign busy          = busy_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_level_calib_ctrl.sv
// Directed bench for level_calib_ctrl: vector tables plus multi-cycle sequences.
module tb_level_calib_ctrl;

  logic        clk_100MHz = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] sample = '0;
  logic        sample_valid = 1'b0;
  logic        reset_button_in = 1'b0;
  logic        saveH_in = 1'b0;
  logic        saveL_in = 1'b0;
  logic [11:0] level_high, level_low;
  logic [6:0]  percent;
  logic        percent_valid, calib_error, busy;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [11:0] smp;
    logic [6:0]  pct;
    int          lat;
  } vec_t;

  vec_t tab_a[5];
  vec_t tab_b[7];
  logic [31:0] exp_q[$];

  level_calib_ctrl dut (
    .clk_100MHz      (clk_100MHz),
    .reset           (reset),
    .sample          (sample),
    .sample_valid    (sample_valid),
    .reset_button_in (reset_button_in),
    .saveH_in        (saveH_in),
    .saveL_in        (saveL_in),
    .level_high      (level_high),
    .level_low       (level_low),
    .percent         (percent),
    .percent_valid   (percent_valid),
    .calib_error     (calib_error),
    .busy            (busy),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  always #5 clk_100MHz = ~clk_100MHz;

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one sample at the next edge (edge 0) and wait for percent_valid.
  task automatic convert(input logic [11:0] v, input logic [6:0] exp_pct,
                         input int exp_lat, input string tag);
    int n;
    bit busy_ok;
    n = 0;
    busy_ok = 1'b1;
    sample = v;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    while (percent_valid !== 1'b1 && n < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      n++;
    end
    check({tag, " latency"}, n, exp_lat);
    check({tag, " percent"}, percent, exp_pct);
    check({tag, " busy window"}, busy_ok, 1);
    check({tag, " busy at done"}, busy, 0);
    tick();
    check({tag, " valid one cycle"}, percent_valid, 0);
  endtask

  task automatic hold_button(input int which, input logic [11:0] mid_sample);
    for (int i = 0; i < 500; i++) begin
      if (which == 0) saveL_in = 1'b1; else saveH_in = 1'b1;
      if (i == 250) begin
        sample = mid_sample;
        sample_valid = 1'b1;
      end else begin
        sample_valid = 1'b0;
      end
      tick();
    end
    saveL_in = 1'b0;
    saveH_in = 1'b0;
    sample_valid = 1'b0;
    tick();
  endtask

  initial begin
    int pulses, pulse_edge, pulse_pct;

    tab_a[0] = '{12'd2048, 7'd50,  21};
    tab_a[1] = '{12'd4095, 7'd100, 2};
    tab_a[2] = '{12'd0,    7'd0,   2};
    tab_a[3] = '{12'd1,    7'd0,   21};
    tab_a[4] = '{12'd4094, 7'd99,  21};

    tab_b[0] = '{12'd2000, 7'd50,  21};
    tab_b[1] = '{12'd1500, 7'd25,  21};
    tab_b[2] = '{12'd900,  7'd0,   2};
    tab_b[3] = '{12'd3500, 7'd100, 2};
    tab_b[4] = '{12'd1000, 7'd0,   2};
    tab_b[5] = '{12'd3000, 7'd100, 2};
    tab_b[6] = '{12'd2999, 7'd99,  21};

    // reset values
    tick();
    tick();
    exp_q = '{32'd4095, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    check("rst level_high", level_high, exp_q.pop_front());
    check("rst level_low", level_low, exp_q.pop_front());
    check("rst percent", percent, exp_q.pop_front());
    check("rst percent_valid", percent_valid, exp_q.pop_front());
    check("rst calib_error", calib_error, exp_q.pop_front());
    check("rst busy", busy, exp_q.pop_front());
    check("rst state", dbg_state, exp_q.pop_front());
    reset = 1'b0;
    tick();

    foreach (tab_a[i]) convert(tab_a[i].smp, tab_a[i].pct, tab_a[i].lat, $sformatf("def[%0d]", i));

    // calibrate low=1000, high=3000 with long held buttons
    convert(12'd1000, 7'd24, 21, "pre_l");
    hold_button(0, 12'd2222);
    check("cal level_low", level_low, 1000);
    check("cal level_high untouched", level_high, 4095);
    convert(12'd3000, 7'd64, 21, "pre_h");
    hold_button(1, 12'd3333);
    check("cal level_high", level_high, 3000);
    check("cal level_low kept", level_low, 1000);
    check("cal calib_error", calib_error, 0);

    foreach (tab_b[i]) convert(tab_b[i].smp, tab_b[i].pct, tab_b[i].lat, $sformatf("cal[%0d]", i));

    // saveH and saveL in the same cycle
    convert(12'd1234, 7'd11, 21, "pre_hl");
    saveH_in = 1'b1;
    saveL_in = 1'b1;
    tick();
    check("hl level_high", level_high, 1234);
    check("hl level_low", level_low, 1234);
    check("hl calib_error lag", calib_error, 0);
    tick();
    check("hl calib_error", calib_error, 1);
    saveH_in = 1'b0;
    saveL_in = 1'b0;
    tick();
    convert(12'd2000, 7'd0, 2, "err_conv");

    // reset_button wins over saveH
    reset_button_in = 1'b1;
    saveH_in = 1'b1;
    tick();
    check("rb level_high", level_high, 4095);
    check("rb level_low", level_low, 0);
    tick();
    check("rb calib_error", calib_error, 0);
    reset_button_in = 1'b0;
    saveH_in = 1'b0;
    tick();

    // overlapping sample during a conversion
    pulses = 0;
    pulse_edge = -1;
    pulse_pct = -1;
    sample = 12'd2048;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      if (e == 5) begin
        sample = 12'd100;
        sample_valid = 1'b1;
      end else begin
        sample_valid = 1'b0;
      end
      tick();
      if (percent_valid === 1'b1) begin
        pulses++;
        pulse_edge = e;
        pulse_pct = percent;
      end
    end
    check("ovl pulses", pulses, 1);
    check("ovl edge", pulse_edge, 21);
    check("ovl percent", pulse_pct, 50);
    saveL_in = 1'b1;
    tick();
    saveL_in = 1'b0;
    tick();
    check("ovl last_sample via saveL", level_low, 100);
    reset_button_in = 1'b1;
    tick();
    reset_button_in = 1'b0;
    tick();
    check("ovl restore level_low", level_low, 0);

    // asynchronous reset in the middle of a division
    sample = 12'd2048;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    for (int e = 1; e <= 9; e++) tick();
    check("abort busy before", busy, 1);
    check("abort state before", dbg_state, 2);
    #2;
    reset = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort state", dbg_state, 0);
    check("abort percent", percent, 0);
    check("abort percent_valid", percent_valid, 0);
    check("abort level_high", level_high, 4095);
    pulses = 0;
    for (int e = 0; e < 3; e++) begin
      tick();
      if (percent_valid !== 1'b0) pulses++;
    end
    reset = 1'b0;
    for (int e = 0; e < 25; e++) begin
      tick();
      if (percent_valid !== 1'b0) pulses++;
    end
    check("abort no valid", pulses, 0);
    convert(12'd4095, 7'd100, 2, "post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
